// File: rtl/obi_apb_bridge.sv
`default_nettype none
// ============================================================================
// Module   : obi_apb_bridge
// Purpose  : Bridges single OBI data requests onto an APB master port.
//            One transaction is in flight at a time; partial-word writes are
//            rejected locally with an error response, and a stalled ACCESS
//            phase is aborted after TIMEOUT_CYCLES wait cycles.
// Ports    : clk_i, rst_ni            clock, asynchronous active-low reset
//            data_*                   OBI request / response (core side)
//            paddr_o..penable_o       APB master request
//            prdata_i..pslverr_i      APB completer response
// Revision : 1.0 - initial release
// ============================================================================
module obi_apb_bridge #(
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    // OBI request
    input  logic                        data_req_i,
    output logic                        data_gnt_o,
    input  logic                        data_we_i,
    input  logic [APB_DATA_WIDTH/8-1:0] data_be_i,
    input  logic [APB_ADDR_WIDTH-1:0]   data_addr_i,
    input  logic [APB_DATA_WIDTH-1:0]   data_wdata_i,
    // OBI response
    output logic                        data_rvalid_o,
    output logic [APB_DATA_WIDTH-1:0]   data_rdata_o,
    output logic                        data_err_o,
    // APB master
    output logic [APB_ADDR_WIDTH-1:0]   paddr_o,
    output logic [APB_DATA_WIDTH-1:0]   pwdata_o,
    output logic                        pwrite_o,
    output logic                        psel_o,
    output logic                        penable_o,
    input  logic [APB_DATA_WIDTH-1:0]   prdata_i,
    input  logic                        pready_i,
    input  logic                        pslverr_i
);

    localparam int c_CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [c_CNT_W:0] c_TIMEOUT = (c_CNT_W + 1)'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W:0]     w_cnt_inc;
    logic                 w_timeout;
    logic                 w_accept;
    logic                 w_partial_wr;

    // A request is accepted whenever one is presented while idle.
    assign w_accept     = data_req_i && (r_state == IDLE);
    assign w_partial_wr = data_we_i && !(&data_be_i);

    // The wait cycle being completed now is the (r_cnt+1)-th; reaching the
    // limit on that cycle ends the ACCESS phase after exactly TIMEOUT_CYCLES
    // ACCESS cycles.
    assign w_cnt_inc = {1'b0, r_cnt} + (c_CNT_W + 1)'(1);
    assign w_timeout = (TIMEOUT_CYCLES != 0) && (w_cnt_inc == c_TIMEOUT);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and APB/OBI handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        data_gnt_o   = 1'b0;
        psel_o       = 1'b0;
        penable_o    = 1'b0;
        case (r_state)
            IDLE: begin
                data_gnt_o = data_req_i;
                // Partial writes are answered locally and never leave IDLE.
                if (data_req_i && !w_partial_wr) begin
                    w_state_next = SETUP;
                end
            end
            SETUP: begin
                psel_o       = 1'b1;
                w_state_next = ACCESS;
            end
            ACCESS: begin
                psel_o    = 1'b1;
                penable_o = 1'b1;
                // pready wins over a coincident timeout.
                if (pready_i || w_timeout) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request capture, timeout counter and response generation
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            paddr_o       <= '0;
            pwdata_o      <= '0;
            pwrite_o      <= 1'b0;
            r_cnt         <= '0;
            data_rvalid_o <= 1'b0;
            data_rdata_o  <= '0;
            data_err_o    <= 1'b0;
        end else begin
            data_rvalid_o <= 1'b0;

            if (w_accept) begin
                paddr_o  <= data_addr_i;
                pwdata_o <= data_wdata_i;
                pwrite_o <= data_we_i;
                if (w_partial_wr) begin
                    data_rvalid_o <= 1'b1;
                    data_err_o    <= 1'b1;
                    data_rdata_o  <= '0;
                end
            end

            if (r_state == SETUP) begin
                r_cnt <= '0;
            end

            if (r_state == ACCESS) begin
                if (pready_i) begin
                    data_rvalid_o <= 1'b1;
                    data_rdata_o  <= pwrite_o ? '0 : prdata_i;
                    data_err_o    <= pslverr_i;
                end else if (w_timeout) begin
                    data_rvalid_o <= 1'b1;
                    data_rdata_o  <= '0;
                    data_err_o    <= 1'b1;
                end else begin
                    r_cnt <= w_cnt_inc[c_CNT_W-1:0];
                end
            end
        end
    end

endmodule
`default_nettype wire
